// File: rtl/exec_operand_pkg.sv
// Shared operand-select encodings and constants for the execute operand stage.
package exec_operand_pkg;

  localparam int OP_SEL_W = 2;
  localparam int X0_ADDR  = 0;

  typedef enum logic [OP_SEL_W-1:0] {
    OP1_RS1   = 2'b00,
    OP1_PC    = 2'b01,
    OP1_ZERO  = 2'b10,
    OP1_ZERO2 = 2'b11
  } op1_sel_t;

  typedef enum logic [OP_SEL_W-1:0] {
    OP2_RS2  = 2'b00,
    OP2_IMM  = 2'b01,
    OP2_ONE  = 2'b10,
    OP2_ZERO = 2'b11
  } op2_sel_t;

endpackage

// File: rtl/execute_operand_stage_fwd_select.sv
// Combinational forwarding selector for one register operand; the lowest
// matching source index wins and x0 is never forwarded.
module fwd_select
  import exec_operand_pkg::*;
#(
  parameter int NUM_FWD    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0]         rs_addr,
  input  logic [DATA_WIDTH-1:0]         rs_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data,
  output logic [DATA_WIDTH-1:0]         data,
  output logic                          hit
);

  logic w_not_x0;

  assign w_not_x0 = (rs_addr != REG_ADDR_W'(X0_ADDR));

  // Walk from the oldest source down so the youngest match is written last.
  always_comb begin
    data = rs_data;
    hit  = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (w_not_x0 && fwd_valid[i] &&
          (fwd_rd[i*REG_ADDR_W +: REG_ADDR_W] == rs_addr)) begin
        data = fwd_data[i*DATA_WIDTH +: DATA_WIDTH];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/execute_operand_stage.sv
// Operand select + forwarding + one-entry output register for the ALU.
// Forwarding is built only when OPERAND_FWD_EN is defined.
module execute_operand_stage
  import exec_operand_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_FWD    = 2,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [REG_ADDR_W-1:0]         rs1_addr,
  input  logic [REG_ADDR_W-1:0]         rs2_addr,
  input  logic [DATA_WIDTH-1:0]         rs1_data,
  input  logic [DATA_WIDTH-1:0]         rs2_data,
  input  logic [DATA_WIDTH-1:0]         pc,
  input  logic [DATA_WIDTH-1:0]         immediate,
  input  logic [OP_SEL_W-1:0]           op1_sel,
  input  logic [OP_SEL_W-1:0]           op2_sel,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_rd,
  input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         alu_in1,
  output logic [DATA_WIDTH-1:0]         alu_in2,
  output logic                          fwd_hit1,
  output logic                          fwd_hit2
);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_alu_in1;
  logic [DATA_WIDTH-1:0] r_alu_in2;
  logic                  r_fwd_hit1;
  logic                  r_fwd_hit2;

  logic [DATA_WIDTH-1:0] w_rs1_val;
  logic [DATA_WIDTH-1:0] w_rs2_val;
  logic                  w_rs1_hit;
  logic                  w_rs2_hit;
  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;
  logic                  w_hit1;
  logic                  w_hit2;
  logic                  w_capture;

`ifdef OPERAND_FWD_EN
  fwd_select #(
    .NUM_FWD(NUM_FWD), .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs1 (
    .rs_addr(rs1_addr), .rs_data(rs1_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(w_rs1_val), .hit(w_rs1_hit)
  );

  fwd_select #(
    .NUM_FWD(NUM_FWD), .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_rs2 (
    .rs_addr(rs2_addr), .rs_data(rs2_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .data(w_rs2_val), .hit(w_rs2_hit)
  );
`else
  logic w_unused_fwd;

  assign w_unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, rs1_addr, rs2_addr};
  assign w_rs1_val    = rs1_data;
  assign w_rs2_val    = rs2_data;
  assign w_rs1_hit    = 1'b0;
  assign w_rs2_hit    = 1'b0;
`endif

  always_comb begin
    w_op1  = '0;
    w_hit1 = 1'b0;
    case (op1_sel_t'(op1_sel))
      OP1_RS1: begin
        w_op1  = w_rs1_val;
        w_hit1 = w_rs1_hit;
      end
      OP1_PC:  w_op1 = pc;
      default: w_op1 = '0;
    endcase
  end

  always_comb begin
    w_op2  = '0;
    w_hit2 = 1'b0;
    case (op2_sel_t'(op2_sel))
      OP2_RS2: begin
        w_op2  = w_rs2_val;
        w_hit2 = w_rs2_hit;
      end
      OP2_IMM: w_op2 = immediate;
      OP2_ONE: w_op2 = DATA_WIDTH'(1);
      default: w_op2 = '0;
    endcase
  end

  // Handshake: an entry moves when valid && ready on a rising edge; the held
  // entry stays stable while out_valid && !out_ready; a drain and a new
  // capture may happen on the same edge; flush drops both held and incoming.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_alu_in1   <= '0;
      r_alu_in2   <= '0;
      r_fwd_hit1  <= 1'b0;
      r_fwd_hit2  <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_alu_in1   <= w_op1;
      r_alu_in2   <= w_op2;
      r_fwd_hit1  <= w_hit1;
      r_fwd_hit2  <= w_hit2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_in1   = r_alu_in1;
  assign alu_in2   = r_alu_in2;
  assign fwd_hit1  = r_fwd_hit1;
  assign fwd_hit2  = r_fwd_hit2;

endmodule
